// File: rtl/rr_packed_logb_gearbox_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_gearbox_pkg
// Description : Shared types and helpers for the packed logb gearbox:
//               flush state encoding, almful threshold, parameter checks.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_gearbox_pkg;

    // Flush sequencer states
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PAD   = 2'd1,
        DRAIN = 2'd2
    } flush_state_t;

    // FIFO occupancy at which upstream must stop sending; the slack covers
    // beats still in flight through the merge tree.
    function automatic int almful_thresh(input int depth, input int slack);
        return depth - slack;
    endfunction

    // Legal configuration: input fits in one beat, FIFO is a power of two
    // of at least 4 entries, and the slack leaves a positive threshold.
    function automatic bit params_legal(input int in_w, input int out_w,
                                        input int depth, input int slack);
        return (in_w > 0) && (in_w <= out_w) && (depth >= 4) &&
               ((depth & (depth - 1)) == 0) && (slack < depth) && (slack >= 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_packed_logb_gearbox_if.sv
`default_nettype none
// ============================================================================
// Module      : rr_packed_logb_gearbox_if
// Description : Bundle of the gearbox data, handshake, flush and status
//               signals. master = upstream/consumer side, slave = gearbox.
// Revision    : 1.0 - initial release
// ============================================================================
interface rr_packed_logb_gearbox_if #(
    parameter int IN_WIDTH  = 512,
    parameter int LEN_WIDTH = $clog2(IN_WIDTH + 1),
    parameter int OUT_WIDTH = 512
) ();
    logic                 in_valid;
    logic [IN_WIDTH-1:0]  in_data;
    logic [LEN_WIDTH-1:0] in_len;
    logic                 logb_almful;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 flush_req;
    logic                 flush_busy;
    logic                 flush_done;
    logic                 overflow_err;
    logic [63:0]          stat_bits;
    logic [63:0]          stat_beats;

    modport master (
        output in_valid, in_data, in_len, out_ready, flush_req,
        input  logb_almful, out_valid, out_data, flush_busy, flush_done,
               overflow_err, stat_bits, stat_beats
    );

    modport slave (
        input  in_valid, in_data, in_len, out_ready, flush_req,
        output logb_almful, out_valid, out_data, flush_busy, flush_done,
               overflow_err, stat_bits, stat_beats
    );
endinterface
`default_nettype wire

// File: rtl/rr_packed_logb_gearbox_beat_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rr_beat_fifo
// Description : Synchronous FIFO with a registered head-of-queue output.
//               Push and pop in the same cycle are accepted even when full;
//               a push when full without a pop is dropped and flagged.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_beat_fifo #(
    parameter  int WIDTH = 512,
    parameter  int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             rstn,
    input  wire logic             i_push,
    input  wire logic             i_pop,
    input  wire logic [WIDTH-1:0] i_data,
    output logic      [WIDTH-1:0] o_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic      [CNT_W-1:0] o_count,
    output logic      [CNT_W-1:0] o_next_count,
    output logic                  o_drop
);
    localparam logic [CNT_W-1:0] c_depth = DEPTH[CNT_W-1:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd;
    logic [PTR_W-1:0] r_wr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_head;

    logic             w_pop_eff;
    logic             w_push_eff;
    logic [PTR_W-1:0] w_rd_next;
    logic [CNT_W-1:0] w_remain;

    assign o_full     = (r_count == c_depth);
    assign o_empty    = (r_count == '0);
    assign w_pop_eff  = i_pop && !o_empty;
    assign w_push_eff = i_push && (!o_full || w_pop_eff);
    assign o_drop     = i_push && !w_push_eff;
    assign w_rd_next  = r_rd + {{(PTR_W-1){1'b0}}, w_pop_eff};
    // Entries still stored after this cycle's pop, before the push lands
    assign w_remain   = r_count - {{(CNT_W-1){1'b0}}, w_pop_eff};
    assign o_next_count = w_remain + {{(CNT_W-1){1'b0}}, w_push_eff};
    assign o_count    = r_count;
    assign o_data     = r_head;

    // Storage array write
    always_ff @(posedge clk) begin
        if (w_push_eff) begin
            r_mem[r_wr] <= i_data;
        end
    end

    // Pointers, occupancy and head register; the head only moves on a pop or
    // on a push into an empty FIFO, so it holds still while stalled.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            r_head  <= '0;
        end else begin
            r_rd    <= w_rd_next;
            r_wr    <= r_wr + {{(PTR_W-1){1'b0}}, w_push_eff};
            r_count <= o_next_count;
            if (w_pop_eff || (o_empty && w_push_eff)) begin
                r_head <= (w_remain == '0) ? i_data : r_mem[w_rd_next];
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/rr_packed_logb_gearbox.sv
`default_nettype none
// ============================================================================
// Module      : rr_packed_logb_gearbox
// Description : Packs the variable-length logb stream into fixed OUT_WIDTH
//               beats, generates logb_almful from beat-FIFO occupancy and
//               runs the end-of-record pad/drain flush sequence.
//               Optional counters enabled by macro RR_GEARBOX_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_packed_logb_gearbox
    import rr_gearbox_pkg::*;
#(
    parameter int IN_WIDTH     = 512,
    parameter int LEN_WIDTH    = $clog2(IN_WIDTH + 1),
    parameter int OUT_WIDTH    = 512,
    parameter int FIFO_DEPTH   = 16,
    parameter int ALMFUL_SLACK = 8
) (
    input  wire logic             clk,
    input  wire logic             rstn,
    rr_packed_logb_gearbox_if.slave bus
);
    localparam int ACC_W      = 2 * OUT_WIDTH;
    localparam int FILL_W     = $clog2(ACC_W);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int THRESH_I   = almful_thresh(FIFO_DEPTH, ALMFUL_SLACK);
    localparam logic [FILL_W:0]  c_out_w  = OUT_WIDTH[FILL_W:0];
    localparam logic [CNT_W-1:0] c_thresh = THRESH_I[CNT_W-1:0];

    if (!params_legal(IN_WIDTH, OUT_WIDTH, FIFO_DEPTH, ALMFUL_SLACK)) begin : g_param_check
        $error("rr_packed_logb_gearbox: illegal parameter combination");
    end

    flush_state_t          r_state;
    logic [ACC_W-1:0]      r_acc;
    logic [FILL_W-1:0]     r_fill;
    logic                  r_almful;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_ovf;

    logic                  w_accept;
    logic [IN_WIDTH-1:0]   w_mask;
    logic [ACC_W-1:0]      w_ins;
    logic [ACC_W-1:0]      w_acc_ins;
    logic [FILL_W:0]       w_sum;
    logic [FILL_W-1:0]     w_fill_next;
    logic                  w_in_push;
    logic                  w_pad_room;
    logic                  w_pad_push;
    logic                  w_push;
    logic                  w_pop;
    logic [OUT_WIDTH-1:0]  w_push_data;
    logic [OUT_WIDTH-1:0]  w_fifo_data;
    logic                  w_full;
    logic                  w_empty;
    logic [CNT_W-1:0]      w_count;
    logic [CNT_W-1:0]      w_next_count;
    logic                  w_drop;

    // Input alignment: mask bits above in_len and place the rest at fill
    assign w_accept    = bus.in_valid && (bus.in_len != '0);
    assign w_mask      = ~({IN_WIDTH{1'b1}} << bus.in_len);
    assign w_ins       = {{(ACC_W-IN_WIDTH){1'b0}}, bus.in_data & w_mask};
    assign w_acc_ins   = r_acc | (w_ins << r_fill);
    assign w_sum       = {1'b0, r_fill} + {{(FILL_W+1-LEN_WIDTH){1'b0}}, bus.in_len};
    assign w_in_push   = w_accept && (w_sum >= c_out_w);
    assign w_fill_next = FILL_W'(w_in_push ? (w_sum - c_out_w) : w_sum);

    // Padding: bits of acc at and above fill are always zero, so the low
    // beat already carries the zero pad.
    assign w_pop       = !w_empty && bus.out_ready;
    assign w_pad_room  = !w_full || w_pop;
    assign w_pad_push  = (r_state == PAD) && !w_accept && (r_fill != '0) && w_pad_room;
    assign w_push      = w_in_push || w_pad_push;
    assign w_push_data = w_in_push ? w_acc_ins[OUT_WIDTH-1:0] : r_acc[OUT_WIDTH-1:0];

    rr_beat_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rstn         (rstn),
        .i_push       (w_push),
        .i_pop        (w_pop),
        .i_data       (w_push_data),
        .o_data       (w_fifo_data),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_count      (w_count),
        .o_next_count (w_next_count),
        .o_drop       (w_drop)
    );

    // Accumulator and fill counter update
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_acc  <= '0;
            r_fill <= '0;
        end else if (w_accept) begin
            r_acc  <= w_in_push ? (w_acc_ins >> OUT_WIDTH) : w_acc_ins;
            r_fill <= w_fill_next;
        end else if (w_pad_push) begin
            r_acc  <= '0;
            r_fill <= '0;
        end
    end

    // Flush sequencer with registered busy/done outputs. Completion also
    // waits for a cycle with no accepted input so a word landing in the
    // same cycle is never left behind in the accumulator.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= RUN;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                RUN: begin
                    if (bus.flush_req) begin
                        r_state <= PAD;
                        r_busy  <= 1'b1;
                    end
                end
                PAD: begin
                    if (!w_accept && ((r_fill == '0) || w_pad_room)) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (r_fill != '0) begin
                        r_state <= PAD;
                    end else if ((w_count == '0) && !w_accept) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= RUN;
                    end
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    // Backpressure flag and sticky overflow flag
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_almful <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_almful <= (w_next_count >= c_thresh);
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

`ifdef RR_GEARBOX_STATS_EN
    logic [63:0] r_stat_bits;
    logic [63:0] r_stat_beats;

    // Payload-bit and popped-beat counters, free-running and wrapping
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_stat_bits  <= '0;
            r_stat_beats <= '0;
        end else begin
            if (w_accept) begin
                r_stat_bits <= r_stat_bits + {{(64-LEN_WIDTH){1'b0}}, bus.in_len};
            end
            if (w_pop) begin
                r_stat_beats <= r_stat_beats + 64'd1;
            end
        end
    end
    assign bus.stat_bits  = r_stat_bits;
    assign bus.stat_beats = r_stat_beats;
`else
    assign bus.stat_bits  = '0;
    assign bus.stat_beats = '0;
`endif

    assign bus.logb_almful  = r_almful;
    assign bus.out_valid    = !w_empty;
    assign bus.out_data     = w_fifo_data;
    assign bus.flush_busy   = r_busy;
    assign bus.flush_done   = r_done;
    assign bus.overflow_err = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_rr_packed_logb_gearbox.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_packed_logb_gearbox
// Description : Randomised scoreboard bench for rr_packed_logb_gearbox. The
//               reference keeps the stream as a queue of bits and cuts beats
//               from it; a negedge monitor checks every presented beat.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_packed_logb_gearbox;
    localparam int IW    = 512;
    localparam int OW    = 512;
    localparam int LW    = 10;
    localparam int DEPTH = 16;
    localparam int THR   = 8;
`ifdef RR_GEARBOX_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    rr_packed_logb_gearbox_if #(.IN_WIDTH(IW), .LEN_WIDTH(LW), .OUT_WIDTH(OW)) bus ();

    rr_packed_logb_gearbox #(
        .IN_WIDTH(IW), .LEN_WIDTH(LW), .OUT_WIDTH(OW),
        .FIFO_DEPTH(DEPTH), .ALMFUL_SLACK(8)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference state
    bit              bq[$];       // accepted bits not yet cut into a beat
    logic [OW-1:0]   exp_q[$];    // beats expected at the output, in order
    int              mcount;      // beats held in the output FIFO
    int              mph;         // 0 running, 1 padding, 2 draining
    bit              e_busy, e_done, e_ovf, e_almful;
    longint unsigned e_bits, e_beats;

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [IW-1:0] rnd_data();
        logic [IW-1:0] r;
        for (int i = 0; i < IW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_push(input logic [OW-1:0] b, input bit pop);
        if (mcount < DEPTH || pop) begin
            exp_q.push_back(b);
            mcount++;
        end else begin
            e_ovf = 1'b1;
        end
    endtask

    task automatic model_reset();
        bq.delete();
        exp_q.delete();
        mcount = 0; mph = 0;
        e_busy = 0; e_done = 0; e_ovf = 0; e_almful = 0;
        e_bits = 0; e_beats = 0;
    endtask

    task automatic compare_outputs();
        check("out_valid",  bus.out_valid,   mcount > 0);
        check("almful",     bus.logb_almful, e_almful);
        check("flush_busy", bus.flush_busy,  e_busy);
        check("flush_done", bus.flush_done,  e_done);
        check("overflow",   bus.overflow_err, e_ovf);
        check("stat_bits",  bus.stat_bits,   STATS_ON ? e_bits  : 64'd0);
        check("stat_beats", bus.stat_beats,  STATS_ON ? e_beats : 64'd0);
    endtask

    // One clock: drive inputs, advance the reference, then check after the edge
    task automatic step(input bit v, input int len, input logic [IW-1:0] d,
                        input bit rdy, input bit fl);
        bit acc, pop;
        int fill0, cnt0;
        logic [OW-1:0] b;
        bus.in_valid  = v;
        bus.in_len    = LW'(len);
        bus.in_data   = d;
        bus.out_ready = rdy;
        bus.flush_req = fl;
        acc   = v && (len != 0);
        pop   = (mcount > 0) && rdy;
        fill0 = bq.size();
        cnt0  = mcount;
        e_done = 1'b0;
        if (acc) begin
            for (int i = 0; i < len; i++) bq.push_back(d[i]);
            e_bits += longint'(len);
            if (bq.size() >= OW) begin
                for (int i = 0; i < OW; i++) b[i] = bq.pop_front();
                model_push(b, pop);
            end
        end
        case (mph)
            0: if (fl) begin mph = 1; e_busy = 1'b1; end
            1: if (!acc) begin
                   if (fill0 == 0) mph = 2;
                   else if (cnt0 < DEPTH || pop) begin
                       b = '0;
                       for (int i = 0; i < fill0; i++) b[i] = bq.pop_front();
                       model_push(b, pop);
                       mph = 2;
                   end
               end
            default: if (fill0 != 0) mph = 1;
                     else if (cnt0 == 0 && !acc) begin
                         e_done = 1'b1; e_busy = 1'b0; mph = 0;
                     end
        endcase
        if (pop) begin mcount--; e_beats++; end
        e_almful = (mcount >= THR);
        @(posedge clk); #1;
        compare_outputs();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 0, '0, rdy, 1'b0);
    endtask

    task automatic wait_flush_done(input bit rdy);
        int k = 0;
        while (mph != 0 && k < 60) begin
            step(1'b0, 0, '0, rdy, 1'b0);
            k++;
        end
        check("flush_bound", mph == 0, 1'b1);
    endtask

    // Monitor: every presented beat must be the scoreboard head, so a
    // stalled beat is also checked to stay unchanged.
    always @(negedge clk) begin
        if (rstn === 1'b1 && bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL beat_unexpected: got %0h expected none", bus.out_data);
            end else begin
                check("beat", bus.out_data, exp_q[0]);
                if (bus.out_ready === 1'b1) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        rstn = 1'b0;
        bus.in_valid = 0; bus.in_len = '0; bus.in_data = '0;
        bus.out_ready = 0; bus.flush_req = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_outputs();
        rstn = 1'b1;

        // Three 200-bit words: one beat, 88 bits left over
        for (int i = 0; i < 3; i++) step(1'b1, 200, rnd_data(), 1'b1, 1'b0);
        idle(3, 1'b1);
        check("fill_88", bq.size(), 88);

        // Flush with no input: padded beat then done
        step(1'b0, 0, '0, 1'b1, 1'b1);
        wait_flush_done(1'b1);

        // Ten 100-bit words, then flush
        for (int i = 0; i < 10; i++) step(1'b1, 100, rnd_data(), 1'b1, 1'b0);
        idle(2, 1'b1);
        step(1'b0, 0, '0, 1'b1, 1'b1);
        wait_flush_done(1'b1);

        // Input arriving while draining sends the sequencer back to padding
        step(1'b1, 100, rnd_data(), 1'b0, 1'b0);
        step(1'b0, 0, '0, 1'b0, 1'b1);
        for (int k = 0; k < 10 && mph != 2; k++) step(1'b0, 0, '0, 1'b0, 1'b0);
        check("in_drain", mph, 2);
        step(1'b1, 300, rnd_data(), 1'b0, 1'b0);
        wait_flush_done(1'b1);

        // Full-width words with the consumer stalled: almful, then overflow
        for (int i = 0; i < 20; i++) step(1'b1, 512, rnd_data(), 1'b0, 1'b0);
        idle(24, 1'b1);

        // Random traffic with toggling ready and occasional flushes
        for (int i = 0; i < 400; i++)
            step(($urandom % 4) != 0, int'($urandom_range(0, 512)), rnd_data(),
                 i[0], ($urandom % 50) == 0);
        idle(30, 1'b1);
        step(1'b0, 0, '0, 1'b1, 1'b1);
        wait_flush_done(1'b1);
        idle(4, 1'b1);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
